// File: rtl/writeback_unit.sv
// Writeback stage: in-order result FIFO committing to the register file via store_now/store_done.
// Optional macro WB_FWD_EN adds combinational forwarding lookups (q_reg*/q_hit*/q_val*).
module writeback_unit #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [3:0]                in_dest,
    input  logic [15:0]               in_val,
    output logic [3:0]                dest_reg,
    output logic [15:0]               dest_val,
    output logic                      store_now,
    input  logic                      store_done,
    output logic                      busy,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      err
`ifdef WB_FWD_EN
    ,
    input  logic [3:0]                q_reg1,
    input  logic [3:0]                q_reg2,
    output logic                      q_hit1,
    output logic                      q_hit2,
    output logic [15:0]               q_val1,
    output logic [15:0]               q_val2
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMR_W = 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_STORE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    typedef struct packed {
        logic [3:0]  dest;
        logic [15:0] val;
    } wb_entry_t;

    wb_entry_t          mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [1:0]         state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [3:0]         dest_reg_q, dest_reg_d;
    logic [15:0]        dest_val_q, dest_val_d;
    logic               store_now_q, store_now_d;
    logic               err_q, err_d;
    logic               push;
    logic               pop;
    wb_entry_t          head;

    // A pop in this cycle never frees a slot for this cycle's push
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign push      = in_valid && in_ready;
    assign head      = mem_q[rd_ptr_q];

    assign dest_reg  = dest_reg_q;
    assign dest_val  = dest_val_q;
    assign store_now = store_now_q;
    assign count     = count_q;
    assign err       = err_q;
    assign busy      = (state_q != S_IDLE) || (count_q != '0);

    // Commit FSM: IDLE -> STORE -> GAP -> (STORE | IDLE)
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        dest_reg_d = dest_reg_q;
        dest_val_d = dest_val_q;
        err_d      = err_q;
        pop        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    dest_reg_d = head.dest;
                    dest_val_d = head.val;
                    timer_d    = '0;
                    state_d    = S_STORE;
                end
            end
            S_STORE: begin
                if (store_done) begin
                    pop     = 1'b1;
                    state_d = S_GAP;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    pop     = 1'b1;
                    state_d = S_GAP;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_GAP: begin
                if (count_q != '0) begin
                    dest_reg_d = head.dest;
                    dest_val_d = head.val;
                    timer_d    = '0;
                    state_d    = S_STORE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        store_now_d = (state_d == S_STORE);
    end

    // FIFO pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            dest_reg_q  <= '0;
            dest_val_q  <= '0;
            store_now_q <= 1'b0;
            err_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            dest_reg_q  <= dest_reg_d;
            dest_val_q  <= dest_val_d;
            store_now_q <= store_now_d;
            err_q       <= err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Payload storage; validity is tracked by the pointers, so no reset is needed
    always_ff @(posedge clk) begin
        if (push && rst) begin
            mem_q[wr_ptr_q] <= '{dest: in_dest, val: in_val};
        end
    end

`ifdef WB_FWD_EN
    // Walk valid entries oldest to youngest so the youngest match wins
    always_comb begin
        q_hit1 = 1'b0;
        q_hit2 = 1'b0;
        q_val1 = '0;
        q_val2 = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count_q) begin
                if (mem_q[rd_ptr_q + PTR_W'(i)].dest == q_reg1) begin
                    q_hit1 = 1'b1;
                    q_val1 = mem_q[rd_ptr_q + PTR_W'(i)].val;
                end
                if (mem_q[rd_ptr_q + PTR_W'(i)].dest == q_reg2) begin
                    q_hit2 = 1'b1;
                    q_val2 = mem_q[rd_ptr_q + PTR_W'(i)].val;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Randomized self-checking bench for writeback_unit with a transaction-level reference model.
module tb_writeback_unit;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_dest = '0;
    logic [15:0] in_val = '0;
    logic [3:0]  dest_reg;
    logic [15:0] dest_val;
    logic        store_now;
    logic        store_done = 1'b0;
    logic        busy;
    logic [2:0]  count;
    logic        err;
`ifdef WB_FWD_EN
    logic [3:0]  q_reg1 = '0;
    logic [3:0]  q_reg2 = '0;
    logic        q_hit1, q_hit2;
    logic [15:0] q_val1, q_val2;
`endif

    writeback_unit #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_dest    (in_dest),
        .in_val     (in_val),
        .dest_reg   (dest_reg),
        .dest_val   (dest_val),
        .store_now  (store_now),
        .store_done (store_done),
        .busy       (busy),
        .count      (count),
        .err        (err)
`ifdef WB_FWD_EN
        ,
        .q_reg1     (q_reg1),
        .q_reg2     (q_reg2),
        .q_hit1     (q_hit1),
        .q_hit2     (q_hit2),
        .q_val1     (q_val1),
        .q_val2     (q_val2)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending entries in push order plus protocol expectations
    typedef struct {
        logic [3:0]  d;
        logic [15:0] v;
    } ent_t;

    ent_t        exp_q[$];
    logic        m_err  = 1'b0;
    logic        exp_sn = 1'b0;
    logic        in_gap = 1'b0;
    int          hi_cnt = 0;
    logic [3:0]  last_d = '0;
    logic [15:0] last_v = '0;

    always @(negedge clk) begin
        if (!rst) begin
            check("rst_store_now", 32'(store_now), 32'd0);
            check("rst_count", 32'(count), 32'd0);
            check("rst_in_ready", 32'(in_ready), 32'd1);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_err", 32'(err), 32'd0);
            check("rst_dest", {12'd0, dest_reg, dest_val}, 32'd0);
`ifdef WB_FWD_EN
            check("rst_q_hit", {30'd0, q_hit1, q_hit2}, 32'd0);
`endif
            exp_q.delete();
            m_err  = 1'b0;
            exp_sn = 1'b0;
            in_gap = 1'b0;
            hi_cnt = 0;
            last_d = '0;
            last_v = '0;
        end else begin
            automatic int   sz    = exp_q.size();
            automatic logic pop   = 1'b0;
            automatic logic ended = 1'b0;
            automatic logic acc;
            check("count", 32'(count), 32'(sz));
            check("in_ready", 32'(in_ready), 32'(sz < DEPTH));
            check("store_now", 32'(store_now), 32'(exp_sn));
            check("err", 32'(err), 32'(m_err));
            check("busy", 32'(busy), 32'((sz != 0) || exp_sn || in_gap));
`ifdef WB_FWD_EN
            begin
                automatic logic        h1 = 1'b0, h2 = 1'b0;
                automatic logic [15:0] v1 = '0, v2 = '0;
                foreach (exp_q[k]) begin
                    if (exp_q[k].d == q_reg1) begin h1 = 1'b1; v1 = exp_q[k].v; end
                    if (exp_q[k].d == q_reg2) begin h2 = 1'b1; v2 = exp_q[k].v; end
                end
                check("fwd1", {15'd0, q_hit1, q_val1}, {15'd0, h1, v1});
                check("fwd2", {15'd0, q_hit2, q_val2}, {15'd0, h2, v2});
            end
`endif
            if (exp_sn) begin
                if (sz == 0) begin
                    check("store_without_entry", 32'd0, 32'd1);
                end else begin
                    check("commit_dest", {12'd0, dest_reg, dest_val}, {12'd0, exp_q[0].d, exp_q[0].v});
                    last_d = exp_q[0].d;
                    last_v = exp_q[0].v;
                end
                if (store_done) begin
                    pop = 1'b1; ended = 1'b1; hi_cnt = 0;
                end else begin
                    hi_cnt++;
                    if (hi_cnt == int'(TIMEOUT)) begin
                        pop = 1'b1; ended = 1'b1; hi_cnt = 0; m_err = 1'b1;
                    end
                end
            end else begin
                check("hold_dest", {12'd0, dest_reg, dest_val}, {12'd0, last_d, last_v});
            end
            acc    = in_valid && (sz < DEPTH);
            in_gap = ended;
            exp_sn = exp_sn ? !ended : (sz > 0);
            if (pop && sz > 0) void'(exp_q.pop_front());
            if (acc) exp_q.push_back('{d: in_dest, v: in_val});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [3:0] d, input logic [15:0] v);
        in_valid = 1'b1;
        in_dest  = d;
        in_val   = v;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stall;
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();

        // Single result, immediate acknowledge
        store_done = 1'b1;
        push_one(4'd3, 16'h1234);
        check("t1_sn_edge_n", 32'(store_now), 32'd0);
        tick();
        check("t1_sn_edge_n1", 32'(store_now), 32'd1);
        check("t1_dest", {12'd0, dest_reg, dest_val}, {12'd0, 4'd3, 16'h1234});
        tick();
        check("t1_sn_gap", 32'(store_now), 32'd0);
        check("t1_busy_gap", 32'(busy), 32'd1);
        tick();
        check("t1_busy_idle", 32'(busy), 32'd0);

        // Fill past capacity while the register file stalls
        store_done = 1'b0;
        in_valid   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_dest = 4'(i + 8);
            in_val  = 16'(16'hA000 + i);
            tick();
        end
        in_valid = 1'b0;
        check("t2_full_count", 32'(count), 32'd4);
        check("t2_full_ready", 32'(in_ready), 32'd0);
        store_done = 1'b1;
        repeat (12) tick();
        check("t2_drained", 32'(count), 32'd0);

        // Watchdog abort, err stays sticky afterwards
        store_done = 1'b0;
        push_one(4'd1, 16'hDEAD);
        repeat (TIMEOUT + 3) tick();
        check("t3_err", 32'(err), 32'd1);
        check("t3_dropped", 32'(count), 32'd0);
        store_done = 1'b1;
        push_one(4'd2, 16'h0002);
        push_one(4'd4, 16'h0004);
        repeat (8) tick();
        check("t3_err_sticky", 32'(err), 32'd1);

        // Reset in the middle of a store
        store_done = 1'b0;
        push_one(4'd5, 16'h0005);
        push_one(4'd6, 16'h0006);
        push_one(4'd7, 16'h0007);
        for (int i = 0; i < 50 && !store_now; i++) tick();
        check("t4_store_seen", 32'(store_now), 32'd1);
        check("t4_count3", 32'(count), 32'd3);
        rst = 1'b0;
        #1;
        check("t4_async_sn", 32'(store_now), 32'd0);
        check("t4_async_count", 32'(count), 32'd0);
        check("t4_async_ready", 32'(in_ready), 32'd1);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_no_store", 32'(store_now), 32'd0);
        end

`ifdef WB_FWD_EN
        // Forwarding returns the youngest pending value
        store_done = 1'b0;
        push_one(4'd7, 16'h00AA);
        push_one(4'd7, 16'h00BB);
        q_reg1 = 4'd7;
        q_reg2 = 4'd2;
        #1;
        check("t5_hit1", 32'(q_hit1), 32'd1);
        check("t5_val1", 32'(q_val1), 32'h00BB);
        check("t5_hit2", 32'(q_hit2), 32'd0);
        check("t5_val2", 32'(q_val2), 32'd0);
        store_done = 1'b1;
        repeat (8) tick();
`endif

        // Random traffic with occasional long stalls and one reset
        stall = 0;
        for (int c = 0; c < 3000; c++) begin
            in_valid = ($urandom_range(0, 9) < 6);
            in_dest  = 4'($urandom);
            in_val   = 16'($urandom);
`ifdef WB_FWD_EN
            q_reg1 = 4'($urandom);
            q_reg2 = 4'($urandom);
`endif
            if (stall > 0) begin
                stall--;
                store_done = 1'b0;
            end else if ($urandom_range(0, 59) == 0) begin
                stall = 20;
                store_done = 1'b0;
            end else begin
                store_done = 1'($urandom);
            end
            if (c == 1500) begin
                in_valid = 1'b0;
                rst = 1'b0;
                tick();
                rst = 1'b1;
            end
            tick();
        end

        in_valid   = 1'b0;
        store_done = 1'b1;
        repeat (20) tick();
        check("final_empty", 32'(count), 32'd0);
        check("final_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Writeback stage of the 3-stage pipeline: the writer side of the register file's store handshake. It accepts completed results (destination register, 16-bit value) from the execute stage and buffers them in a small in-order FIFO. It commits them one at a time to the register file with a store_now / store_done handshake. A watchdog flags a register file that never acknowledges.

## Interface
- DEPTH, 4: FIFO entries (power of two, 2..16)
- TIMEOUT, 15: maximum STORE cycles without store_done before abort (1..255)

- clk  input  1  pipeline clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low
- in_valid  input  1  execute stage presents a result
- in_ready  output  1  FIFO can accept (not full)
- in_dest  input  4  destination register of result
- in_val  input  16  result value
- dest_reg  output  4  register index to write (drives register file destReg)
- dest_val  output  16  value to write (drives register file destVal)
- store_now  output  1  store request to register file
- store_done  input  1  register file store acknowledge
- busy  output  1  FIFO non-empty or FSM not IDLE
- count  output  $clog2(DEPTH)+1  FIFO occupancy
- err  output  1  sticky: a store timed out
- q_reg1, q_reg2  input  4  forwarding query registers (WB_FWD_EN only)
- q_hit1, q_hit2  output  1  query matches a pending entry (WB_FWD_EN only)
- q_val1, q_val2  output  16  forwarded value (WB_FWD_EN only)

## Operation
- Push: in_valid && in_ready at a clock edge writes {in_dest, in_val} at the tail. in_valid while full is ignored, with no side effect.
- in_ready = (count != DEPTH), combinational from registered count. A pop in the same cycle does not free a slot for that cycle's push.
- FSM states:
  - IDLE: store_now=0. If FIFO is non-empty, load the head into dest_reg/dest_val, clear the timer, and go to STORE.
  - STORE: store_now=1, dest_reg/dest_val held stable. Sampling store_done=1 pops the head and goes to GAP. Otherwise the timer increments. When the timer reaches TIMEOUT, set err, pop (drop) the head, and go to GAP.
  - GAP: store_now=0 for exactly one cycle, guaranteeing a fresh rising edge on store_now. If the FIFO is non-empty, load the new head and go to STORE; otherwise go to IDLE.
- store_done is sampled only in STORE and ignored elsewhere.
- Commit order equals push order. Two pending writes to the same register both commit, oldest first.
- Simultaneous push and pop: count unchanged, pointers both advance, wrap modulo DEPTH.
- dest_reg/dest_val keep the last committed entry while IDLE/GAP.
- err clears only on reset.

## Timing
- Reset (async assert, low): state IDLE, FIFO empty, count=0, in_ready=1, busy=0, store_now=0, dest_reg=0, dest_val=0, err=0, q_hit*=0. Asserting reset during STORE drops store_now immediately and discards all entries.
- Latency: push at edge N gives store_now=1 after edge N+1 if the FSM was IDLE.
- Throughput: one commit per 2 cycles when store_done is high on the first STORE sample.
- Timeout: store_now stays high for exactly TIMEOUT cycles, then err rises with GAP.
- busy falls on the edge that enters IDLE with an empty FIFO.

## Configuration
- WB_FWD_EN defined: q_* ports exist. q_hitK = 1 if any valid FIFO entry (head included) has dest == q_regK. q_valK = the value of the youngest matching entry, otherwise 0. The lookup is purely combinational from registered FIFO state.
- WB_FWD_EN undefined: q_* ports and match logic are absent, and the rest of the behaviour is identical.

## Test plan
- Reset then push {3, 0x1234}, store_done tied 1 -> store_now high for exactly 1 cycle starting after the next edge, with dest_reg=3, dest_val=0x1234; busy returns to 0 after 3 edges.
- Push 5 results back-to-back with DEPTH=4, store_done=0 -> in_ready=0 after 4 pushes, 5th ignored, count=4; release store_done=1 -> 4 commits in push order, each separated by one store_now-low cycle.
- Hold store_done=0 with TIMEOUT=15 -> store_now high 15 cycles, then err=1 and entry dropped; err stays 1 through later successful stores until rst low.
- Assert rst low mid-STORE with 3 entries queued -> store_now=0 immediately, count=0, in_ready=1, no further stores after release.
- WB_FWD_EN: push {7, 0x00AA} then {7, 0x00BB}, store_done=0, q_reg1=7 -> q_hit1=1, q_val1=0x00BB; q_reg2=2 -> q_hit2=0, q_val2=0.
